// File: rtl/hdmi_rx_capture_ctrl.sv
// hdmi_rx_capture_ctrl
// Captures one complete active video frame from the ADV7611 into the pixel
// write FIFO. An arm pulse waits for the next frame start, then every active
// pixel is pushed with its linear frame address until H_ACTIVE*V_ACTIVE
// pixels have been accounted for. Done / overflow / short-frame flags are
// sticky until the next arm. Single clock domain (adv7611_clk); the FIFO
// does the crossing to the memory clock.
//
// Ports:
//   adv7611_clk, resetb       pixel clock, async active-low reset
//   capture_req               one-cycle arm pulse (synchronous)
//   adv7611_hs/vs/de/d        receiver video bus
//   fifo_full                 write FIFO full (sampled at decision time)
//   fifo_wr/data/addr         registered FIFO write port
//   busy                      ARM or CAPTURE
//   done/overflow/frame_err   sticky status
//   state                     FSM state for debug
module hdmi_rx_capture_ctrl #(
  parameter int   H_ACTIVE = 1920,
  parameter int   V_ACTIVE = 1080,
  parameter int   ADDR_W   = 27,
  parameter int   DATA_W   = 32,
  parameter logic VS_POL   = 1'b1
) (
  input  logic              adv7611_clk,
  input  logic              resetb,
  input  logic              capture_req,
  input  logic              adv7611_hs,
  input  logic              adv7611_vs,
  input  logic              adv7611_de,
  input  logic [23:0]       adv7611_d,
  input  logic              fifo_full,
  output logic              fifo_wr,
  output logic [DATA_W-1:0] fifo_data,
  output logic [ADDR_W-1:0] fifo_addr,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              frame_err,
  output logic [1:0]        state
);

  localparam int              FRAME_PIX = H_ACTIVE * V_ACTIVE;
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(FRAME_PIX - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t cur, nxt;

  // input stage
  logic        vs_r, vs_rr, de_r, hs_r;
  logic [23:0] d_r;
  logic        sof;

  // hs is registered alongside the bus for alignment but the capture logic
  // never looks at it.
  logic unused_hs;
  assign unused_hs = hs_r;

  always_ff @(posedge adv7611_clk or negedge resetb) begin
    if (!resetb) begin
      vs_r  <= 1'b0;
      vs_rr <= 1'b0;
      de_r  <= 1'b0;
      hs_r  <= 1'b0;
      d_r   <= '0;
    end else begin
      vs_r  <= adv7611_vs;
      vs_rr <= vs_r;
      de_r  <= adv7611_de;
      hs_r  <= adv7611_hs;
      d_r   <= adv7611_d;
    end
  end

  assign sof = (vs_r == VS_POL) && (vs_rr != VS_POL);

  // next-state values for every registered output
  logic [ADDR_W-1:0] pix_cnt, cnt_n;
  logic              wr_n, done_n, ovf_n, ferr_n;
  logic [DATA_W-1:0] data_n;
  logic [ADDR_W-1:0] addr_n;
  logic              last_px;

  assign last_px = de_r && (pix_cnt == LAST);

  always_comb begin
    nxt    = cur;
    cnt_n  = pix_cnt;
    wr_n   = 1'b0;
    data_n = fifo_data;
    addr_n = fifo_addr;
    done_n = done;
    ovf_n  = overflow;
    ferr_n = frame_err;
    unique case (cur)
      IDLE, DONE: begin
        if (capture_req) begin
          nxt    = ARM;
          cnt_n  = '0;
          done_n = 1'b0;
          ovf_n  = 1'b0;
          ferr_n = 1'b0;
        end
      end
      ARM: begin
        if (sof) begin
          nxt   = CAPTURE;
          cnt_n = '0;
        end
      end
      CAPTURE: begin
        // A new frame start aborts the capture, unless it coincides with the
        // final pixel, which then completes normally.
        if (sof && !last_px) begin
          nxt    = DONE;
          done_n = 1'b1;
          ferr_n = 1'b1;
        end else if (de_r) begin
          if (!fifo_full) begin
            wr_n   = 1'b1;
            data_n = DATA_W'(d_r);
            addr_n = pix_cnt;
          end else begin
            ovf_n  = 1'b1;
          end
          // count dropped pixels too so later addresses stay on-grid
          cnt_n = pix_cnt + ADDR_W'(1);
          if (pix_cnt == LAST) begin
            nxt    = DONE;
            done_n = 1'b1;
          end
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge adv7611_clk or negedge resetb) begin
    if (!resetb) begin
      cur       <= IDLE;
      pix_cnt   <= '0;
      fifo_wr   <= 1'b0;
      fifo_data <= '0;
      fifo_addr <= '0;
      done      <= 1'b0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      cur       <= nxt;
      pix_cnt   <= cnt_n;
      fifo_wr   <= wr_n;
      fifo_data <= data_n;
      fifo_addr <= addr_n;
      done      <= done_n;
      overflow  <= ovf_n;
      frame_err <= ferr_n;
    end
  end

  assign busy  = (cur == ARM) || (cur == CAPTURE);
  assign state = cur;

endmodule

// File: tb/tb_hdmi_rx_capture_ctrl.sv
// Directed bench for hdmi_rx_capture_ctrl with a 4x2 frame.
module tb_hdmi_rx_capture_ctrl;

  localparam int ADDR_W = 27;
  localparam int DATA_W = 32;

  logic              adv7611_clk = 1'b0;
  logic              resetb      = 1'b0;
  logic              capture_req = 1'b0;
  logic              adv7611_hs  = 1'b0;
  logic              adv7611_vs  = 1'b0;
  logic              adv7611_de  = 1'b0;
  logic [23:0]       adv7611_d   = '0;
  logic              fifo_full   = 1'b0;
  logic              fifo_wr;
  logic [DATA_W-1:0] fifo_data;
  logic [ADDR_W-1:0] fifo_addr;
  logic              busy, done, overflow, frame_err;
  logic [1:0]        state;

  hdmi_rx_capture_ctrl #(
    .H_ACTIVE(4), .V_ACTIVE(2), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .VS_POL(1'b1)
  ) dut (
    .adv7611_clk(adv7611_clk), .resetb(resetb), .capture_req(capture_req),
    .adv7611_hs(adv7611_hs), .adv7611_vs(adv7611_vs), .adv7611_de(adv7611_de),
    .adv7611_d(adv7611_d), .fifo_full(fifo_full), .fifo_wr(fifo_wr),
    .fifo_data(fifo_data), .fifo_addr(fifo_addr), .busy(busy), .done(done),
    .overflow(overflow), .frame_err(frame_err), .state(state)
  );

  always #5 adv7611_clk = ~adv7611_clk;

  int n_chk  = 0;
  int n_fail = 0;

  // write log, sampled just after each rising edge
  logic [ADDR_W-1:0] wa[$];
  logic [DATA_W-1:0] wd[$];
  always @(posedge adv7611_clk) begin
    #1;
    if (fifo_wr === 1'b1) begin
      wa.push_back(fifo_addr);
      wd.push_back(fifo_data);
    end
  end

  int skip_g = 0;  // pixel number whose write decision sees fifo_full=1
  int pend   = 0;  // pixel number driven on the previous cycle

  task automatic drive(input logic vs, input logic de, input logic [23:0] d,
                       input logic full);
    @(negedge adv7611_clk);
    adv7611_vs = vs;
    adv7611_de = de;
    adv7611_hs = ~de;
    adv7611_d  = d;
    fifo_full  = full;
  endtask

  // fifo_full is raised one cycle after a pixel is driven, which is when
  // that pixel sits in the input register and its write is decided.
  task automatic step(input logic vs, input logic de, input int k);
    drive(vs, de, de ? 24'(k) : 24'd0, (skip_g != 0) && (pend == skip_g));
    pend = de ? k : 0;
  endtask

  task automatic frame(input int skip, input int vs_at, input bit vs_last);
    skip_g = skip;
    pend   = 0;
    step(1'b1, 1'b0, 0);
    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 0);
    for (int k = 1; k <= 8; k++) begin
      step(vs_last && (k == 8), 1'b1, k);
      if (k == vs_at) step(1'b1, 1'b0, 0);
      if (k % 4 == 0) begin
        step(1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 0);
      end
    end
    repeat (3) step(1'b0, 1'b0, 0);
    skip_g = 0;
  endtask

  task automatic pulse_req();
    @(negedge adv7611_clk);
    capture_req = 1'b1;
    @(negedge adv7611_clk);
    capture_req = 1'b0;
    wa.delete();
    wd.delete();
    n_chk++;
    if (state !== 2'd1 || busy !== 1'b1 || done !== 1'b0 ||
        overflow !== 1'b0 || frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL arm: state=%0d busy=%b done=%b ovf=%b ferr=%b, want 1 1 0 0 0",
               state, busy, done, overflow, frame_err);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge adv7611_clk);
    n_chk++;
    if ({fifo_wr, fifo_data, fifo_addr, busy, done, overflow, frame_err, state} !== '0) begin
      n_fail++;
      $display("FAIL reset_vals: wr=%b data=%0h addr=%0h busy=%b done=%b ovf=%b ferr=%b state=%0d, want all 0",
               fifo_wr, fifo_data, fifo_addr, busy, done, overflow, frame_err, state);
    end
    resetb = 1'b1;
  endtask

  task automatic test_full_frame();
    pulse_req();
    frame(0, 0, 1'b0);
    n_chk++;
    if (wa.size() != 8) begin
      n_fail++;
      $display("FAIL full_count: got %0d writes want 8", wa.size());
    end
    for (int i = 0; i < wa.size() && i < 8; i++) begin
      n_chk++;
      if (wa[i] !== ADDR_W'(i) || wd[i] !== DATA_W'(i + 1)) begin
        n_fail++;
        $display("FAIL full_wr%0d: addr=%0h data=%08h want addr=%0h data=%08h",
                 i, wa[i], wd[i], i, i + 1);
      end
    end
    n_chk++;
    if (done !== 1'b1 || overflow !== 1'b0 || frame_err !== 1'b0 ||
        busy !== 1'b0 || state !== 2'd3) begin
      n_fail++;
      $display("FAIL full_flags: done=%b ovf=%b ferr=%b busy=%b state=%0d want 1 0 0 0 3",
               done, overflow, frame_err, busy, state);
    end
  endtask

  task automatic test_short_frame();
    pulse_req();
    frame(0, 5, 1'b0);
    n_chk++;
    if (wa.size() != 5) begin
      n_fail++;
      $display("FAIL short_count: got %0d writes want 5", wa.size());
    end
    for (int i = 0; i < wa.size() && i < 5; i++) begin
      n_chk++;
      if (wa[i] !== ADDR_W'(i) || wd[i] !== DATA_W'(i + 1)) begin
        n_fail++;
        $display("FAIL short_wr%0d: addr=%0h data=%08h want addr=%0h data=%08h",
                 i, wa[i], wd[i], i, i + 1);
      end
    end
    n_chk++;
    if (done !== 1'b1 || frame_err !== 1'b1 || overflow !== 1'b0 || state !== 2'd3) begin
      n_fail++;
      $display("FAIL short_flags: done=%b ferr=%b ovf=%b state=%0d want 1 1 0 3",
               done, frame_err, overflow, state);
    end
  endtask

  task automatic test_overflow();
    int ea;
    pulse_req();
    frame(3, 0, 1'b0);
    n_chk++;
    if (wa.size() != 7) begin
      n_fail++;
      $display("FAIL ovf_count: got %0d writes want 7", wa.size());
    end
    for (int i = 0; i < wa.size() && i < 7; i++) begin
      ea = (i < 2) ? i : i + 1;
      n_chk++;
      if (wa[i] !== ADDR_W'(ea) || wd[i] !== DATA_W'(ea + 1)) begin
        n_fail++;
        $display("FAIL ovf_wr%0d: addr=%0h data=%08h want addr=%0h data=%08h",
                 i, wa[i], wd[i], ea, ea + 1);
      end
    end
    n_chk++;
    if (done !== 1'b1 || overflow !== 1'b1 || frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_flags: done=%b ovf=%b ferr=%b want 1 1 0", done, overflow, frame_err);
    end
  endtask

  task automatic test_pre_arm();
    pulse_req();
    for (int k = 0; k < 4; k++) drive(1'b0, 1'b1, 24'hAA0000 + 24'(k), 1'b0);
    drive(1'b0, 1'b0, 24'd0, 1'b0);
    drive(1'b0, 1'b0, 24'd0, 1'b0);
    n_chk++;
    if (wa.size() != 0 || state !== 2'd1) begin
      n_fail++;
      $display("FAIL prearm_idle: writes=%0d state=%0d want 0 1", wa.size(), state);
    end
    frame(0, 0, 1'b0);
    n_chk++;
    if (wa.size() != 8) begin
      n_fail++;
      $display("FAIL prearm_count: got %0d writes want 8", wa.size());
    end
    for (int i = 0; i < wa.size() && i < 8; i++) begin
      n_chk++;
      if (wa[i] !== ADDR_W'(i) || wd[i] !== DATA_W'(i + 1)) begin
        n_fail++;
        $display("FAIL prearm_wr%0d: addr=%0h data=%08h want addr=%0h data=%08h",
                 i, wa[i], wd[i], i, i + 1);
      end
    end
  endtask

  // frame start arrives together with the final pixel
  task automatic test_sof_on_last();
    pulse_req();
    frame(0, 0, 1'b1);
    n_chk++;
    if (wa.size() != 8 || done !== 1'b1 || frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL sof_last: writes=%0d done=%b ferr=%b want 8 1 0",
               wa.size(), done, frame_err);
    end
    n_chk++;
    if (wa.size() == 8 && (wa[7] !== ADDR_W'(7) || wd[7] !== 32'h8)) begin
      n_fail++;
      $display("FAIL sof_last_px: addr=%0h data=%08h want 7 00000008", wa[7], wd[7]);
    end
  endtask

  task automatic test_latency_and_reset_mid();
    pulse_req();
    drive(1'b1, 1'b0, 24'd0, 1'b0);
    drive(1'b0, 1'b0, 24'd0, 1'b0);
    drive(1'b0, 1'b0, 24'd0, 1'b0);
    drive(1'b0, 1'b1, 24'h123456, 1'b0);
    drive(1'b0, 1'b0, 24'd0, 1'b0);
    n_chk++;
    if (fifo_wr !== 1'b0) begin
      n_fail++;
      $display("FAIL lat_early: fifo_wr=%b want 0", fifo_wr);
    end
    drive(1'b0, 1'b0, 24'd0, 1'b0);
    n_chk++;
    if (fifo_wr !== 1'b1 || fifo_data !== 32'h00123456 || fifo_addr !== '0 ||
        state !== 2'd2 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL lat_write: wr=%b data=%08h addr=%0h state=%0d busy=%b want 1 00123456 0 2 1",
               fifo_wr, fifo_data, fifo_addr, state, busy);
    end
    drive(1'b0, 1'b1, 24'h000007, 1'b0);
    drive(1'b0, 1'b1, 24'h000008, 1'b0);
    @(negedge adv7611_clk);
    #2 resetb = 1'b0;
    #1;
    n_chk++;
    if ({fifo_wr, fifo_data, fifo_addr, busy, done, overflow, frame_err, state} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: wr=%b data=%0h addr=%0h busy=%b done=%b ovf=%b ferr=%b state=%0d, want all 0",
               fifo_wr, fifo_data, fifo_addr, busy, done, overflow, frame_err, state);
    end
    adv7611_de = 1'b0;
    repeat (2) @(negedge adv7611_clk);
    resetb = 1'b1;
    wa.delete();
    wd.delete();
    frame(0, 0, 1'b0);
    n_chk++;
    if (wa.size() != 0 || state !== 2'd0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset: writes=%0d state=%0d done=%b want 0 0 0",
               wa.size(), state, done);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_short_frame();
    test_overflow();
    test_pre_arm();
    test_sof_on_last();
    test_latency_and_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
